// File: rtl/fifo_controller.sv
// fifo_controller: sequencing controller for an 8-entry register-file FIFO.
// Turns push/pop requests into write/read strobes and slot addresses, and
// keeps occupancy, full/empty flags and per-request ack/error status.
// Optional feature: define FIFO_ALMOST_FLAGS_EN to add almost_full and
// almost_empty outputs (thresholds AF_LEVEL / AE_LEVEL).
//
// Request semantics: wr_en and rd_en are level requests sampled on every
// rising edge; there is no ready signal. The outcome of a request sampled at
// edge k (strobe, address, ack or err) is registered at edge k and is visible
// for the cycle that follows. A request refused because the FIFO is full or
// empty is reported on wr_err/rd_err, except when both requests arrive
// together at a boundary, where the impossible half is dropped silently.
module fifo_controller
`ifdef FIFO_ALMOST_FLAGS_EN
#(
   parameter int AF_LEVEL = 7,
   parameter int AE_LEVEL = 1
)
`endif
(
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic       rd_en,
   output logic       we,
   output logic [2:0] wr_addr,
   output logic       re,
   output logic [2:0] rd_addr,
   output logic [3:0] data_count,
   output logic       full,
   output logic       empty,
   output logic       wr_ack,
   output logic       wr_err,
   output logic       rd_ack,
   output logic       rd_err,
   output logic [2:0] state
`ifdef FIFO_ALMOST_FLAGS_EN
   ,
   output logic       almost_full,
   output logic       almost_empty
`endif
);

   typedef enum logic [2:0] {
      INIT   = 3'd0,
      NO_OP  = 3'd1,
      WRITE  = 3'd2,
      WR_ERR = 3'd3,
      READ   = 3'd4,
      RD_ERR = 3'd5,
      WR_RD  = 3'd6
   } state_t;

   state_t     cur_state;
   state_t     next_state;
   logic [2:0] tail;   // next slot to write
   logic [2:0] head;   // next slot to read
   logic [3:0] cnt;    // occupancy 0..8; pointers wrap modulo 8 on their own

   // Flags decode the registered count only, so they never glitch.
   always_comb begin
      full  = (cnt == 4'd8);
      empty = (cnt == 4'd0);
   end

   assign data_count = cnt;
   assign state      = cur_state;

`ifdef FIFO_ALMOST_FLAGS_EN
   localparam logic [3:0] AF_CNT = AF_LEVEL[3:0];
   localparam logic [3:0] AE_CNT = AE_LEVEL[3:0];

   // Almost flags are threshold compares on the registered count.
   always_comb begin
      almost_full  = (cnt >= AF_CNT);
      almost_empty = (cnt <= AE_CNT);
   end
`endif

   // Request decode: choose the next state from the requests and current flags.
   // INIT needs no special case because the decode ignores the current state.
   always_comb begin
      next_state = NO_OP;
      case ({wr_en, rd_en})
         2'b10:   next_state = full  ? WR_ERR : WRITE;
         2'b01:   next_state = empty ? RD_ERR : READ;
         2'b11: begin
            if (empty)     next_state = WRITE;   // pop dropped silently
            else if (full) next_state = READ;    // push dropped silently
            else           next_state = WR_RD;
         end
         default: next_state = NO_OP;
      endcase
   end

   // State register plus all registered actions of the state being entered.
   // Addresses are only loaded with their strobe, so they hold otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= INIT;
         tail      <= 3'd0;
         head      <= 3'd0;
         cnt       <= 4'd0;
         we        <= 1'b0;
         re        <= 1'b0;
         wr_addr   <= 3'd0;
         rd_addr   <= 3'd0;
         wr_ack    <= 1'b0;
         wr_err    <= 1'b0;
         rd_ack    <= 1'b0;
         rd_err    <= 1'b0;
      end else begin
         cur_state <= next_state;
         we        <= 1'b0;
         re        <= 1'b0;
         wr_ack    <= 1'b0;
         wr_err    <= 1'b0;
         rd_ack    <= 1'b0;
         rd_err    <= 1'b0;
         case (next_state)
            WRITE: begin
               we      <= 1'b1;
               wr_addr <= tail;
               tail    <= tail + 3'd1;
               cnt     <= cnt + 4'd1;
               wr_ack  <= 1'b1;
            end
            READ: begin
               re      <= 1'b1;
               rd_addr <= head;
               head    <= head + 3'd1;
               cnt     <= cnt - 4'd1;
               rd_ack  <= 1'b1;
            end
            WR_RD: begin
               // cnt is 1..7 here, so head and tail never collide
               we      <= 1'b1;
               wr_addr <= tail;
               tail    <= tail + 3'd1;
               wr_ack  <= 1'b1;
               re      <= 1'b1;
               rd_addr <= head;
               head    <= head + 3'd1;
               rd_ack  <= 1'b1;
            end
            WR_ERR:  wr_err <= 1'b1;
            RD_ERR:  rd_err <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_controller.sv
// tb_fifo_controller: directed plus random stimulus for fifo_controller,
// checked against a reference model that tracks the FIFO as a queue of
// occupied slot numbers and a running count of accepted pushes.
module tb_fifo_controller;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic       rd_en;
   logic       we;
   logic [2:0] wr_addr;
   logic       re;
   logic [2:0] rd_addr;
   logic [3:0] data_count;
   logic       full;
   logic       empty;
   logic       wr_ack;
   logic       wr_err;
   logic       rd_ack;
   logic       rd_err;
   logic [2:0] state;
`ifdef FIFO_ALMOST_FLAGS_EN
   logic       almost_full;
   logic       almost_empty;
`endif

   fifo_controller dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .we         (we),
      .wr_addr    (wr_addr),
      .re         (re),
      .rd_addr    (rd_addr),
      .data_count (data_count),
      .full       (full),
      .empty      (empty),
      .wr_ack     (wr_ack),
      .wr_err     (wr_err),
      .rd_ack     (rd_ack),
      .rd_err     (rd_err),
      .state      (state)
`ifdef FIFO_ALMOST_FLAGS_EN
      ,
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`endif
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int step_no  = 0;

   // reference model: slots currently holding data, oldest first
   logic [2:0] exp_q[$];
   int         wr_total;
   logic       e_we, e_re, e_wack, e_werr, e_rack, e_rerr;
   logic [2:0] e_wa, e_ra, e_state;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      wr_total = 0;
      e_we = 0; e_re = 0; e_wack = 0; e_werr = 0; e_rack = 0; e_rerr = 0;
      e_wa = 3'd0; e_ra = 3'd0; e_state = 3'd0;
   endtask

   // Outcome of one clock edge with the given requests, from the FIFO rules.
   task automatic model_edge(input logic w, input logic r);
      logic is_full, is_empty, do_w, do_r;
      is_full  = (exp_q.size() == 8);
      is_empty = (exp_q.size() == 0);
      do_w     = w && !is_full;
      do_r     = r && !is_empty;
      e_we   = do_w;
      e_wack = do_w;
      e_re   = do_r;
      e_rack = do_r;
      e_werr = w && !r && is_full;
      e_rerr = r && !w && is_empty;
      if (do_r) e_ra = exp_q.pop_front();
      if (do_w) begin
         e_wa = 3'(wr_total % 8);
         wr_total++;
         exp_q.push_back(e_wa);
      end
      if (do_w && do_r)  e_state = 3'd6;
      else if (do_w)     e_state = 3'd2;
      else if (do_r)     e_state = 3'd4;
      else if (e_werr)   e_state = 3'd3;
      else if (e_rerr)   e_state = 3'd5;
      else               e_state = 3'd1;
   endtask

   task automatic compare_all();
      int n;
      n = exp_q.size();
      check("we",         8'(we),         8'(e_we));
      check("re",         8'(re),         8'(e_re));
      check("wr_addr",    8'(wr_addr),    8'(e_wa));
      check("rd_addr",    8'(rd_addr),    8'(e_ra));
      check("data_count", 8'(data_count), 8'(n));
      check("full",       8'(full),       8'(n == 8));
      check("empty",      8'(empty),      8'(n == 0));
      check("wr_ack",     8'(wr_ack),     8'(e_wack));
      check("wr_err",     8'(wr_err),     8'(e_werr));
      check("rd_ack",     8'(rd_ack),     8'(e_rack));
      check("rd_err",     8'(rd_err),     8'(e_rerr));
      check("state",      8'(state),      8'(e_state));
`ifdef FIFO_ALMOST_FLAGS_EN
      check("almost_full",  8'(almost_full),  8'(n >= 7));
      check("almost_empty", 8'(almost_empty), 8'(n <= 1));
`endif
   endtask

   // driver: present requests, clock once, compare after the edge
   task automatic step(input logic w, input logic r);
      wr_en = w;
      rd_en = r;
      model_edge(w, r);
      @(posedge clk);
      #1;
      step_no++;
      compare_all();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
      reset = 1'b1;
      model_reset();
      #1;
      compare_all();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      compare_all();
      reset = 1'b0;

      // fill: addresses 0..7, then full
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
      check("count_at_full", 8'(data_count), 8'd8);
      check("full_at_full",  8'(full),       8'd1);

      // push while full
      step(1'b1, 1'b0);
      check("wr_err_state", 8'(state), 8'd3);

      // drain: addresses 0..7, then a pop while empty
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
      check("empty_after_drain", 8'(empty), 8'd1);
      step(1'b0, 1'b1);
      check("rd_err_when_empty", 8'(rd_err), 8'd1);

      // wrap with simultaneous requests: head=3 tail=5 count=2 after reset
      apply_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
      check("wr_rd_state", 8'(state),      8'd6);
      check("wr_rd_count", 8'(data_count), 8'd2);

      // boundaries: both requests from empty, then from full
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      check("both_from_empty", 8'(data_count), 8'd1);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      check("both_from_full", 8'(data_count), 8'd7);

      // reset mid-operation after four writes
      apply_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      apply_reset();
      check("reset_empty", 8'(empty), 8'd1);
      step(1'b1, 1'b0);
      check("write_after_reset", 8'(wr_addr), 8'd0);

      // random traffic, alternating between write-heavy and read-heavy phases
      for (int i = 0; i < 400; i++) begin
         logic w, r;
         if ((i / 40) % 2 == 0) begin
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) == 0);
         end else begin
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) != 0);
         end
         step(w, r);
         if (i == 250) apply_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_controller.md
Name: fifo_controller

Overview:
- Sequencing controller for the 8-entry register-file FIFO.
- Accepts push/pop requests and generates the write enable and 3-bit write address consumed by the write-operation decoder.
- Generates the read enable and 3-bit read address for the read mux.
- Maintains occupancy, full/empty flags and per-request ack/error status through a registered state machine.

Parameters:
- AF_LEVEL, 7, almost-full threshold; only used when FIFO_ALMOST_FLAGS_EN is defined.
- AE_LEVEL, 1, almost-empty threshold; only used when FIFO_ALMOST_FLAGS_EN is defined.
- Depth is fixed at 8 and address width at 3 (matches the 3-to-8 write decoder); neither is parameterised.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  push request, sampled each rising edge.
- rd_en  input  1  pop request, sampled each rising edge.
- we  output  1  write strobe to the write decoder.
- wr_addr  output  3  slot being written.
- re  output  1  read strobe to the read mux.
- rd_addr  output  3  slot being read.
- data_count  output  4  occupancy, 0..8.
- full  output  1  data_count == 8.
- empty  output  1  data_count == 0.
- wr_ack  output  1  previous-cycle push accepted.
- wr_err  output  1  previous-cycle push rejected (full).
- rd_ack  output  1  previous-cycle pop accepted.
- rd_err  output  1  previous-cycle pop rejected (empty).
- state  output  3  current FSM state, for debug.

Behaviour:
- Single clock domain; reset is asynchronous and active-high.
- Reset (immediate, any cycle, including mid-operation):
  - head = tail = 0, data_count = 0, state = INIT.
  - we, re, wr_addr, rd_addr, wr_ack, wr_err, rd_ack, rd_err all 0.
  - empty = 1, full = 0.
- Internal registers: tail[2:0] (next write slot), head[2:0] (next read slot), cnt[3:0].
- Pointer arithmetic is modulo 8: 7 -> 0 with no extra wrap bit. Full/empty are derived from cnt only.
- full and empty are combinational decodes of the registered cnt, so they are glitch-free.
- State encoding: INIT=0, NO_OP=1, WRITE=2, WR_ERR=3, READ=4, RD_ERR=5, WR_RD=6.
- Transitions are evaluated at every edge from any state. INIT is left unconditionally on the first edge after reset and is treated like NO_OP.
- Request decode at each edge, with full/empty taken from the current cnt:
  - wr_en=0, rd_en=0 -> NO_OP.
  - wr_en=1, rd_en=0:
    - !full -> WRITE.
    - full -> WR_ERR.
  - wr_en=0, rd_en=1:
    - !empty -> READ.
    - empty -> RD_ERR.
  - wr_en=1, rd_en=1:
    - !full and !empty -> WR_RD.
    - empty -> WRITE. No rd_err; the pop is dropped silently.
    - full -> READ. No wr_err; the push is dropped silently.
- Registered actions per next state. Every flag and strobe not listed is 0.
  - WRITE: we=1, wr_addr=tail, tail+1, cnt+1, wr_ack=1.
  - READ: re=1, rd_addr=head, head+1, cnt-1, rd_ack=1.
  - WR_RD: both of the above; cnt unchanged.
  - WR_ERR: wr_err=1; pointers and cnt unchanged.
  - RD_ERR: rd_err=1; pointers and cnt unchanged.
  - NO_OP: no action.
- wr_addr and rd_addr hold their last value when the matching strobe is 0.
- Latency:
  - Request sampled at edge k; strobe, address and ack/err are valid during cycle k..k+1.
  - Datapath registers capture at edge k+1. The source holds write data through edge k+1.
  - data_count updates at edge k; full/empty follow in the same cycle.
- A write and a read in WR_RD never target the same slot, because cnt is between 1 and 7.
- Back-to-back requests every cycle are supported; strobes stay high continuously.

Optional Feature:
- Macro: FIFO_ALMOST_FLAGS_EN.
- Defined:
  - Adds output almost_full (1 bit) = data_count >= AF_LEVEL.
  - Adds output almost_empty (1 bit) = data_count <= AE_LEVEL.
  - Both are combinational from the registered count. Reset values: almost_full=0, almost_empty=1.
- Undefined: neither port exists, and AF_LEVEL/AE_LEVEL are unused. All other behaviour is identical.

Test Plan:
- Reset, then 8 consecutive wr_en cycles:
  - wr_addr sequence 0..7 with we=1 and wr_ack=1 each cycle.
  - data_count reaches 8; full=1, empty=0.
- From full, wr_en for 1 cycle -> wr_err=1, we=0, data_count stays 8, state=3.
- From full, 8 consecutive rd_en cycles:
  - rd_addr sequence 0..7, rd_ack=1 each cycle.
  - data_count=0, empty=1.
  - A 9th rd_en gives rd_err=1, re=0.
- Wrap plus simultaneous requests:
  - Write 5, read 3 (head=3, tail=5, count=2).
  - Assert wr_en and rd_en together for 6 cycles:
    - we and re high every cycle; count stays 2.
    - wr_addr 5,6,7,0,1,2 and rd_addr 3,4,5,6,7,0; state=6.
- Simultaneous requests at the boundaries:
  - From empty, wr_en=rd_en=1 -> WRITE only: count=1, rd_err=0.
  - From full, wr_en=rd_en=1 -> READ only: count=7, wr_err=0.
- Reset mid-operation:
  - After writing 4 entries, assert reset between clock edges.
  - All outputs go to 0 immediately and empty=1.
  - The next write uses wr_addr=0.
  - With FIFO_ALMOST_FLAGS_EN defined: almost_full=1 at count 7, almost_empty=1 at count 1.
